// File: rtl/panda_risc_v_dispatcher_sb.sv
// Registered dispatch stage with an internal per-register pending-write scoreboard.
// Optional define PANDA_DISPATCH_WAW_STALL_EN: stall on any outstanding write to the RD.
module panda_risc_v_dispatcher_sb #(
  parameter int CHN_N        = 4,
  parameter int MSG_W        = 71,
  parameter int RETIRE_N     = 2,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic                  clk,
  input  logic                  sys_resetn,
  input  logic [MSG_W-1:0]      s_req_msg,
  input  logic [CHN_N-1:0]      s_req_chn_sel,
  input  logic [31:0]           s_req_pc,
  input  logic [4:0]            s_req_rd_id,
  input  logic                  s_req_rd_vld,
  input  logic [2:0]            s_req_err_code,
  input  logic                  s_req_valid,
  output logic                  s_req_ready,
  output logic [MSG_W-1:0]      m_alu_msg,
  output logic [31:0]           m_alu_pc,
  output logic [4:0]            m_alu_rd_id,
  output logic                  m_alu_rd_vld,
  output logic [2:0]            m_alu_err_code,
  output logic                  m_alu_is_long_inst,
  output logic                  m_alu_valid,
  input  logic                  m_alu_ready,
  output logic [MSG_W-1:0]      m_exu_msg,
  output logic [4:0]            m_exu_rd_id,
  output logic [CHN_N-1:0]      m_exu_valid,
  input  logic [CHN_N-1:0]      m_exu_ready,
  input  logic [5*RETIRE_N-1:0] retire_rd_id,
  input  logic [RETIRE_N-1:0]   retire_vld,
  input  logic [9:0]            chk_rs_id,
  output logic [1:0]            chk_rs_busy,
  output logic                  sb_busy
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int SUM_W = CNT_W + $clog2(RETIRE_N + 1) + 1;
`ifdef PANDA_DISPATCH_WAW_STALL_EN
  localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(1);
`else
  localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(MAX_INFLIGHT);
`endif

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];

  logic [MSG_W-1:0] msg_q;
  logic [31:0]      pc_q;
  logic [4:0]       rd_id_q;
  logic             rd_vld_q;
  logic [2:0]       err_q;
  logic [CHN_N-1:0] chn_q;
  logic             alu_pend_q, alu_pend_d;
  logic             exu_pend_q, exu_pend_d;

  logic hazard;
  logic out_empty;
  logic out_completing;
  logic exu_hs;
  logic accept;

  assign hazard = s_req_rd_vld & (s_req_rd_id != 5'd0) & (cnt_q[s_req_rd_id] >= STALL_TH);
  assign exu_hs = exu_pend_q & (|(chn_q & m_exu_ready));

  // The entry can be replaced this cycle only if every side still owed a handshake gets it now.
  assign out_empty      = ~alu_pend_q & ~exu_pend_q;
  assign out_completing = (~alu_pend_q | m_alu_ready) & (~exu_pend_q | exu_hs);
  assign s_req_ready    = ~hazard & (out_empty | out_completing);
  assign accept         = s_req_valid & s_req_ready;

  // NOTE: every signal driven here gets a value on every path first, so no latch is inferred.
  always_comb begin
    alu_pend_d = alu_pend_q & ~m_alu_ready;
    exu_pend_d = exu_pend_q & ~exu_hs;
    if (accept) begin
      alu_pend_d = 1'b1;
      exu_pend_d = (|s_req_chn_sel) & ~s_req_err_code[2];
    end
  end

  // Increment and decrements on the same RD net out; decrements below zero are dropped.
  always_comb begin
    for (int r = 0; r < 32; r++) begin : g_cnt
      logic [SUM_W-1:0] up;
      logic [SUM_W-1:0] dn;
      up = SUM_W'(cnt_q[r]);
      dn = '0;
      if (accept && s_req_rd_vld && (s_req_rd_id == 5'(r))) up = up + SUM_W'(1);
      for (int k = 0; k < RETIRE_N; k++) begin
        if (retire_vld[k] && (retire_rd_id[5*k +: 5] == 5'(r))) dn = dn + SUM_W'(1);
      end
      cnt_d[r] = ((r == 0) || (dn >= up)) ? '0 : CNT_W'(up - dn);
    end
  end

  // NOTE: the counter array is reset explicitly because an aborted run must drop all pending writes.
  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update order-independent.
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_ff @(posedge clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      msg_q      <= '0;
      pc_q       <= '0;
      rd_id_q    <= '0;
      rd_vld_q   <= 1'b0;
      err_q      <= '0;
      chn_q      <= '0;
      alu_pend_q <= 1'b0;
      exu_pend_q <= 1'b0;
    end else begin
      alu_pend_q <= alu_pend_d;
      exu_pend_q <= exu_pend_d;
      if (accept) begin
        msg_q    <= s_req_msg;
        pc_q     <= s_req_pc;
        rd_id_q  <= s_req_rd_id;
        rd_vld_q <= s_req_rd_vld;
        err_q    <= s_req_err_code;
        chn_q    <= s_req_chn_sel;
      end
    end
  end

  assign m_alu_msg          = msg_q;
  assign m_alu_pc           = pc_q;
  assign m_alu_rd_id        = rd_id_q;
  assign m_alu_rd_vld       = rd_vld_q;
  assign m_alu_err_code     = err_q;
  assign m_alu_is_long_inst = |chn_q;
  assign m_alu_valid        = alu_pend_q;
  assign m_exu_msg          = msg_q;
  assign m_exu_rd_id        = rd_id_q;
  assign m_exu_valid        = {CHN_N{exu_pend_q}} & chn_q;

  assign chk_rs_busy[0] = cnt_q[chk_rs_id[4:0]] != '0;
  assign chk_rs_busy[1] = cnt_q[chk_rs_id[9:5]] != '0;

  always_comb begin
    sb_busy = 1'b0;
    for (int r = 0; r < 32; r++) sb_busy = sb_busy | (cnt_q[r] != '0);
  end

endmodule

// File: tb/tb_panda_risc_v_dispatcher_sb.sv
// Scoreboard bench for panda_risc_v_dispatcher_sb: directed scenarios followed by random traffic.
module tb_panda_risc_v_dispatcher_sb;

  localparam int CHN_N = 4;
  localparam int MSG_W = 71;
  localparam int RETIRE_N = 2;
  localparam int MAX_INFLIGHT = 3;
`ifdef PANDA_DISPATCH_WAW_STALL_EN
  localparam int TH = 1;
`else
  localparam int TH = MAX_INFLIGHT;
`endif

  logic                  clk = 1'b0;
  logic                  sys_resetn;
  logic [MSG_W-1:0]      s_req_msg;
  logic [CHN_N-1:0]      s_req_chn_sel;
  logic [31:0]           s_req_pc;
  logic [4:0]            s_req_rd_id;
  logic                  s_req_rd_vld;
  logic [2:0]            s_req_err_code;
  logic                  s_req_valid;
  logic                  s_req_ready;
  logic [MSG_W-1:0]      m_alu_msg;
  logic [31:0]           m_alu_pc;
  logic [4:0]            m_alu_rd_id;
  logic                  m_alu_rd_vld;
  logic [2:0]            m_alu_err_code;
  logic                  m_alu_is_long_inst;
  logic                  m_alu_valid;
  logic                  m_alu_ready;
  logic [MSG_W-1:0]      m_exu_msg;
  logic [4:0]            m_exu_rd_id;
  logic [CHN_N-1:0]      m_exu_valid;
  logic [CHN_N-1:0]      m_exu_ready;
  logic [5*RETIRE_N-1:0] retire_rd_id;
  logic [RETIRE_N-1:0]   retire_vld;
  logic [9:0]            chk_rs_id;
  logic [1:0]            chk_rs_busy;
  logic                  sb_busy;

  panda_risc_v_dispatcher_sb #(
    .CHN_N(CHN_N), .MSG_W(MSG_W), .RETIRE_N(RETIRE_N), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .clk(clk), .sys_resetn(sys_resetn),
    .s_req_msg(s_req_msg), .s_req_chn_sel(s_req_chn_sel), .s_req_pc(s_req_pc),
    .s_req_rd_id(s_req_rd_id), .s_req_rd_vld(s_req_rd_vld), .s_req_err_code(s_req_err_code),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .m_alu_msg(m_alu_msg), .m_alu_pc(m_alu_pc), .m_alu_rd_id(m_alu_rd_id),
    .m_alu_rd_vld(m_alu_rd_vld), .m_alu_err_code(m_alu_err_code),
    .m_alu_is_long_inst(m_alu_is_long_inst), .m_alu_valid(m_alu_valid), .m_alu_ready(m_alu_ready),
    .m_exu_msg(m_exu_msg), .m_exu_rd_id(m_exu_rd_id), .m_exu_valid(m_exu_valid),
    .m_exu_ready(m_exu_ready), .retire_rd_id(retire_rd_id), .retire_vld(retire_vld),
    .chk_rs_id(chk_rs_id), .chk_rs_busy(chk_rs_busy), .sb_busy(sb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MSG_W-1:0] msg;
    logic [31:0]      pc;
    logic [4:0]       rd;
    logic             rd_vld;
    logic [2:0]       err;
    logic             lng;
  } alu_item_t;

  typedef struct {
    logic [MSG_W-1:0] msg;
    logic [4:0]       rd;
    logic [CHN_N-1:0] chn;
  } exu_item_t;

  alu_item_t alu_q[$];
  exu_item_t exu_q[$];

  // Reference model: pending-write count per register and the state of the single held entry.
  int               mdl_cnt [32];
  bit               mdl_alu_p;
  bit               mdl_exu_p;
  logic [CHN_N-1:0] mdl_chn;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) mdl_cnt[r] = 0;
    mdl_alu_p = 1'b0;
    mdl_exu_p = 1'b0;
    mdl_chn   = '0;
    alu_q.delete();
    exu_q.delete();
  endtask

  function automatic logic [MSG_W-1:0] rand_msg();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[MSG_W-1:0];
  endfunction

  task automatic idle();
    s_req_valid  = 1'b0;
    s_req_rd_vld = 1'b0;
    retire_vld   = '0;
  endtask

  task automatic req(input logic [31:0] pc, input logic [4:0] rd, input logic rv,
                     input logic [CHN_N-1:0] chn, input logic [2:0] err);
    s_req_valid    = 1'b1;
    s_req_msg      = rand_msg();
    s_req_pc       = pc;
    s_req_rd_id    = rd;
    s_req_rd_vld   = rv;
    s_req_chn_sel  = chn;
    s_req_err_code = err;
  endtask

  // One clock cycle: check combinational outputs against the model, predict the edge, advance.
  task automatic step();
    bit alu_hs, exu_hs, compl, haz, exp_rdy, acc, any_busy;
    int nc;
    alu_item_t ai;
    exu_item_t ei;
    #1;
    compl   = (!mdl_alu_p || m_alu_ready) && (!mdl_exu_p || ((m_exu_ready & mdl_chn) != 0));
    haz     = s_req_rd_vld && (s_req_rd_id != 0) && (mdl_cnt[s_req_rd_id] >= TH);
    exp_rdy = !haz && compl;
    any_busy = 1'b0;
    for (int r = 0; r < 32; r++) if (mdl_cnt[r] > 0) any_busy = 1'b1;
    check("s_req_ready", s_req_ready, exp_rdy);
    check("m_alu_valid", m_alu_valid, mdl_alu_p);
    check("m_exu_valid", m_exu_valid, mdl_exu_p ? mdl_chn : '0);
    check("chk_rs_busy0", chk_rs_busy[0], mdl_cnt[chk_rs_id[4:0]] > 0);
    check("chk_rs_busy1", chk_rs_busy[1], mdl_cnt[chk_rs_id[9:5]] > 0);
    check("sb_busy", sb_busy, any_busy);
    alu_hs = mdl_alu_p && m_alu_ready;
    exu_hs = mdl_exu_p && ((m_exu_ready & mdl_chn) != 0);
    acc    = s_req_valid && exp_rdy;
    if (alu_hs) mdl_alu_p = 1'b0;
    if (exu_hs) mdl_exu_p = 1'b0;
    if (acc) begin
      mdl_alu_p = 1'b1;
      mdl_exu_p = (s_req_chn_sel != 0) && !s_req_err_code[2];
      mdl_chn   = s_req_chn_sel;
      ai = '{msg: s_req_msg, pc: s_req_pc, rd: s_req_rd_id, rd_vld: s_req_rd_vld,
             err: s_req_err_code, lng: (s_req_chn_sel != 0)};
      alu_q.push_back(ai);
      if (mdl_exu_p) begin
        ei = '{msg: s_req_msg, rd: s_req_rd_id, chn: s_req_chn_sel};
        exu_q.push_back(ei);
      end
    end
    for (int r = 1; r < 32; r++) begin
      nc = mdl_cnt[r];
      if (acc && s_req_rd_vld && s_req_rd_id == 5'(r)) nc++;
      for (int k = 0; k < RETIRE_N; k++)
        if (retire_vld[k] && retire_rd_id[5*k +: 5] == 5'(r)) nc--;
      mdl_cnt[r] = (nc < 0) ? 0 : nc;
    end
    @(negedge clk);
  endtask

  // Monitor: pops the expected entry whenever the DUT completes an output handshake.
  initial begin
    alu_item_t ea;
    exu_item_t ee;
    forever begin
      @(negedge clk);
      #3;
      if (sys_resetn) begin
        if (m_alu_valid && m_alu_ready) begin
          check("alu_expected", alu_q.size() != 0, 1'b1);
          if (alu_q.size() != 0) begin
            ea = alu_q.pop_front();
            check("alu_msg", m_alu_msg, ea.msg);
            check("alu_pc", m_alu_pc, ea.pc);
            check("alu_rd_id", m_alu_rd_id, ea.rd);
            check("alu_rd_vld", m_alu_rd_vld, ea.rd_vld);
            check("alu_err", m_alu_err_code, ea.err);
            check("alu_long", m_alu_is_long_inst, ea.lng);
          end
        end
        if ((m_exu_valid & m_exu_ready) != 0) begin
          check("exu_expected", exu_q.size() != 0, 1'b1);
          if (exu_q.size() != 0) begin
            ee = exu_q.pop_front();
            check("exu_msg", m_exu_msg, ee.msg);
            check("exu_rd_id", m_exu_rd_id, ee.rd);
            check("exu_chn", m_exu_valid, ee.chn);
          end
        end
      end
    end
  end

  initial begin
    int r;
    sys_resetn = 1'b0;
    s_req_msg = '0; s_req_chn_sel = '0; s_req_pc = '0; s_req_rd_id = '0;
    s_req_err_code = '0; retire_rd_id = '0; chk_rs_id = '0;
    m_alu_ready = 1'b1; m_exu_ready = '1;
    idle();
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_alu_valid", m_alu_valid, 1'b0);
    check("rst_exu_valid", m_exu_valid, '0);
    check("rst_sb_busy", sb_busy, 1'b0);
    check("rst_alu_msg", m_alu_msg, '0);
    check("rst_alu_pc", m_alu_pc, '0);
    check("rst_exu_msg", m_exu_msg, '0);
    sys_resetn = 1'b1;
    @(negedge clk);

    // Simple ALU-only write to x5.
    req(32'h100, 5'd5, 1'b1, 4'b0000, 3'b000);
    step();
    idle();
    chk_rs_id = {5'd0, 5'd5};
    #1;
    check("t1_pc", m_alu_pc, 32'h100);
    check("t1_busy5", chk_rs_busy[0], 1'b1);
    check("t1_sb_busy", sb_busy, 1'b1);
    step();

    // Load with a stalled LSU; a follow-up request waits for it.
    req(32'h104, 5'd6, 1'b1, 4'b0001, 3'b000);
    step();
    req(32'h108, 5'd10, 1'b1, 4'b0000, 3'b000);
    m_exu_ready = '0;
    repeat (3) step();
    m_exu_ready = 4'b0001;
    step();
    idle();
    step();

    // Misaligned load/store: ALU only, still flagged long.
    req(32'h10c, 5'd8, 1'b1, 4'b0001, 3'b110);
    m_exu_ready = '0;
    step();
    idle();
    step();
    step();
    m_exu_ready = '1;

    // Repeated writes to x7 until the stall threshold.
    for (int i = 0; i < 4; i++) begin
      req(32'h200 + 32'(4*i), 5'd7, 1'b1, 4'b0000, 3'b000);
      step();
    end
    req(32'h210, 5'd7, 1'b1, 4'b0000, 3'b000);
    #1;
    check("t4_stall", s_req_ready, 1'b0);
    retire_rd_id = {5'd0, 5'd7};
    retire_vld   = 2'b01;
    step();
    retire_vld   = '0;
    #1;
    check("t4_release", s_req_ready, 1'b1);
    step();

    // Double retire on x9 together with a new x9 write; spurious retire on x3.
    req(32'h300, 5'd9, 1'b1, 4'b0000, 3'b000);
    step();
    req(32'h304, 5'd9, 1'b1, 4'b0000, 3'b000);
    step();
    req(32'h308, 5'd9, 1'b1, 4'b0000, 3'b000);
    retire_rd_id = {5'd9, 5'd9};
    retire_vld   = 2'b11;
    step();
    idle();
    chk_rs_id = {5'd3, 5'd9};
`ifndef PANDA_DISPATCH_WAW_STALL_EN
    #1;
    check("t5_busy9", chk_rs_busy[0], 1'b1);
`endif
    retire_rd_id = {5'd0, 5'd3};
    retire_vld   = 2'b01;
    step();
    retire_vld   = '0;
    step();

    // x0 destinations never count and never stall.
    chk_rs_id = {5'd0, 5'd0};
    for (int i = 0; i < 6; i++) begin
      req(32'h400 + 32'(4*i), 5'd0, 1'b1, 4'b0000, 3'b000);
      step();
    end
    idle();
    step();

    // Reset in the middle of a held entry drops everything at once.
    m_alu_ready = 1'b0;
    req(32'h500, 5'd11, 1'b1, 4'b0010, 3'b000);
    step();
    idle();
    sys_resetn = 1'b0;
    #1;
    check("rst_mid_alu_valid", m_alu_valid, 1'b0);
    check("rst_mid_exu_valid", m_exu_valid, '0);
    check("rst_mid_sb_busy", sb_busy, 1'b0);
    model_clear();
    @(negedge clk);
    sys_resetn = 1'b1;
    m_alu_ready = 1'b1;
    @(negedge clk);

    // Random traffic on a small register window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      s_req_valid    = ($urandom_range(0, 3) != 0);
      s_req_msg      = rand_msg();
      s_req_pc       = $urandom;
      s_req_rd_id    = 5'($urandom_range(0, 7));
      s_req_rd_vld   = ($urandom_range(0, 3) != 0);
      r              = $urandom_range(0, 4);
      s_req_chn_sel  = (r == 0) ? 4'b0000 : 4'(1 << (r - 1));
      s_req_err_code = 3'($urandom_range(0, 7));
      m_alu_ready    = ($urandom_range(0, 9) < 7);
      m_exu_ready    = 4'($urandom_range(0, 15));
      retire_vld     = 2'($urandom_range(0, 3)) & {($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0)};
      retire_rd_id   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      chk_rs_id      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      step();
    end

    idle();
    m_alu_ready = 1'b1;
    m_exu_ready = '1;
    repeat (4) step();
    check("alu_q_drained", alu_q.size(), 0);
    check("exu_q_drained", exu_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
